// File: rtl/key_pkg.sv
// Shared types and constants for the front-panel key conditioner.
// Also provides the key channel assignments used by the stopwatch control.
`timescale 1ns/1ps
package key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_HELD = 2'd1,
    KEY_LONG = 2'd2
  } key_state_e;

  localparam int KEY_START = 0;
  localparam int KEY_PAUSE = 1;
  localparam int MS_PER_S  = 1000;

  // Width of a counter that must hold 0..limit; a zero limit still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between raw switch inputs and the conditioned pulse outputs.
// The slave modport is the conditioner; the master modport is its user.
`timescale 1ns/1ps
interface key_conditioner_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;
  logic                ms_tick;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_long, key_repeat, ms_tick
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_long, key_repeat, ms_tick
  );
endinterface

// File: rtl/ms_tick_gen.sv
// Free-running 1 kHz strobe derived from clk; one cycle high per millisecond.
`timescale 1ns/1ps
module ms_tick_gen
  import key_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_start,
  output logic ms_tick
);

  localparam int TICK_DIV = CLK_HZ / MS_PER_S;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_reg;

  always_ff @(posedge clk or posedge reset_start) begin
    if (reset_start) begin
      tick_cnt_reg <= '0;
    end else if (tick_cnt_reg == TICK_LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  assign ms_tick = (tick_cnt_reg == TICK_LAST);

endmodule

// File: rtl/key_conditioner.sv
// Front-panel key conditioner: sync, debounce, press/release edges,
// long-press detection and auto-repeat, independently for each key.
`timescale 1ns/1ps
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 2,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_start,
  key_conditioner_if.slave kif
);

  localparam int DW     = cnt_width(DEBOUNCE_MS);
  localparam int HW     = cnt_width(LONG_MS);
  localparam int RW     = cnt_width(REPEAT_MS);
  localparam bit REP_EN = (REPEAT_MS > 0);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_EN ? REPEAT_MS - 1 : 0);

  logic                ms_tick;
  logic [NUM_KEYS-1:0] level_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;
  logic [NUM_KEYS-1:0] long_vec;
  logic [NUM_KEYS-1:0] repeat_vec;

  ms_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_ms_tick_gen (
    .clk         (clk),
    .reset_start (reset_start),
    .ms_tick     (ms_tick)
  );

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic            sync1_reg;
      logic            sync2_reg;
      logic            k_s;
      logic            level_reg;
      logic            deb_fire;
      logic            rise;
      logic            fall;
      logic [DW-1:0]   deb_cnt_reg;
      logic [HW-1:0]   hold_cnt_reg;
      logic [RW-1:0]   rep_cnt_reg;
      key_state_e      state_reg;
      logic            press_reg;
      logic            release_reg;
      logic            long_reg;
      logic            repeat_reg;

      always_ff @(posedge clk or posedge reset_start) begin
        if (reset_start) begin
          sync1_reg <= ACTIVE_LOW;
          sync2_reg <= ACTIVE_LOW;
        end else begin
          sync1_reg <= kif.key_in[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign k_s = sync2_reg ^ ACTIVE_LOW;

      // The level commits on the tick that would take the count to DEBOUNCE_MS.
      assign deb_fire = (k_s != level_reg) && ms_tick && (deb_cnt_reg == DEB_LAST);
      assign rise     = deb_fire & k_s;
      assign fall     = deb_fire & ~k_s;

      always_ff @(posedge clk or posedge reset_start) begin
        if (reset_start) begin
          level_reg   <= 1'b0;
          deb_cnt_reg <= '0;
        end else if (k_s == level_reg) begin
          deb_cnt_reg <= '0;
        end else if (deb_fire) begin
          level_reg   <= k_s;
          deb_cnt_reg <= '0;
        end else if (ms_tick) begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end

      // A release takes priority over a long/repeat tick in the same cycle.
      always_ff @(posedge clk or posedge reset_start) begin
        if (reset_start) begin
          state_reg    <= KEY_IDLE;
          hold_cnt_reg <= '0;
          rep_cnt_reg  <= '0;
          press_reg    <= 1'b0;
          release_reg  <= 1'b0;
          long_reg     <= 1'b0;
          repeat_reg   <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          long_reg    <= 1'b0;
          repeat_reg  <= 1'b0;
          case (state_reg)
            KEY_IDLE: begin
              if (rise) begin
                press_reg    <= 1'b1;
                state_reg    <= KEY_HELD;
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
              end
            end
            KEY_HELD: begin
              if (fall) begin
                release_reg  <= 1'b1;
                state_reg    <= KEY_IDLE;
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
              end else if (ms_tick) begin
                if (hold_cnt_reg == HOLD_LAST) begin
                  long_reg    <= 1'b1;
                  state_reg   <= KEY_LONG;
                  rep_cnt_reg <= '0;
                end else begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
                end
              end
            end
            KEY_LONG: begin
              if (fall) begin
                release_reg  <= 1'b1;
                state_reg    <= KEY_IDLE;
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
              end else if (ms_tick && REP_EN) begin
                if (rep_cnt_reg == REP_LAST) begin
                  repeat_reg  <= 1'b1;
                  rep_cnt_reg <= '0;
                end else begin
                  rep_cnt_reg <= rep_cnt_reg + 1'b1;
                end
              end
            end
            default: begin
              state_reg    <= KEY_IDLE;
              hold_cnt_reg <= '0;
              rep_cnt_reg  <= '0;
            end
          endcase
        end
      end

      assign level_vec[gi]   = level_reg;
      assign press_vec[gi]   = press_reg;
      assign release_vec[gi] = release_reg;
      assign long_vec[gi]    = long_reg;
      assign repeat_vec[gi]  = repeat_reg;
    end
  endgenerate

  assign kif.key_level   = level_vec;
  assign kif.key_press   = press_vec;
  assign kif.key_release = release_vec;
  assign kif.key_long    = long_vec;
  assign kif.key_repeat  = repeat_vec;
  assign kif.ms_tick     = ms_tick;

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-side companion to the stopwatch display driver. Turns raw, bouncing front-panel switches into clean, single-cycle control pulses.
- Per key: 2-FF synchronizer, millisecond debouncer, press/release edge pulses, long-press detect, auto-repeat.
- Key 0 feeds the start/clear control and key 1 feeds pause/resume. The stopwatch consumes key_press only, never raw levels.

Parameters:
- NUM_KEYS, 2: number of independent key channels.
- CLK_HZ, 50_000_000: clk frequency. Must be a multiple of 1000.
- DEBOUNCE_MS, 20: stable time required before the debounced level changes. Must be >= 1.
- LONG_MS, 1000: hold time after debounced press before key_long fires. Must be >= 1.
- REPEAT_MS, 200: auto-repeat period after key_long. 0 disables repeat.
- ACTIVE_LOW, 1: 1 means raw key_in reads 0 when pressed.

Ports:
- clk  in  1  system clock.
- reset_start  in  1  reset, asynchronous, active-high.
- key_in  in  NUM_KEYS  raw asynchronous switch inputs.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  1-cycle pulse when key_level rises.
- key_release  out  NUM_KEYS  1-cycle pulse when key_level falls.
- key_long  out  NUM_KEYS  1-cycle pulse, once per press, at LONG_MS.
- key_repeat  out  NUM_KEYS  1-cycle pulse every REPEAT_MS after key_long.
- ms_tick  out  1  1 kHz strobe, exported for other blocks.

Behaviour:
- Reset (async, immediate):
  - All outputs are 0.
  - Synchronizer FFs load the inactive raw level (ACTIVE_LOW ? 1 : 0).
  - All counters are 0 and every key FSM is in IDLE.
- Tick:
  - TICK_DIV = CLK_HZ/1000.
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - ms_tick is high for the single cycle in which tick_cnt == TICK_DIV-1.
  - Free-running, never gated.
- Sync: 2 FFs per key. k_s = sync output XOR ACTIVE_LOW, so k_s is active-high.
- Debounce, per key:
  - deb_cnt is cleared on any cycle where k_s == key_level.
  - Otherwise deb_cnt increments on ms_tick.
  - On the ms_tick where deb_cnt reaches DEBOUNCE_MS: key_level <= k_s and deb_cnt <= 0.
  - Any bounce back before that point restarts the count.
  - Latency after the raw edge settles: 2 clk + (DEBOUNCE_MS-1 .. DEBOUNCE_MS) ms.
- Per-key FSM states: IDLE, HELD, LONG.
  - IDLE -> HELD: in the cycle key_level becomes 1, key_press = 1 and hold_cnt <= 0.
  - HELD: hold_cnt increments on ms_tick. On the tick where hold_cnt reaches LONG_MS: key_long = 1, go to LONG, rep_cnt <= 0.
  - LONG: rep_cnt increments on ms_tick. When rep_cnt reaches REPEAT_MS: key_repeat = 1 and rep_cnt <= 0. If REPEAT_MS == 0, no repeat pulses.
  - HELD/LONG -> IDLE: in the cycle key_level becomes 0, key_release = 1 and counters are cleared.
- Pulse rules:
  - All pulses are registered and exactly 1 clk wide.
  - key_press and key_release are mutually exclusive per key.
  - key_long never coincides with key_press; LONG_MS >= 1 tick guarantees this.
  - A release on the same cycle as a long or repeat tick: release wins, and key_long/key_repeat are suppressed.
- Widths:
  - Each counter is $clog2(limit+1) bits.
  - hold_cnt and rep_cnt cannot overflow, because each is cleared or stops at its limit.
- Keys are fully independent. Simultaneous presses produce simultaneous pulses.
- Reset mid-hold:
  - Outputs drop the same instant.
  - After release of reset, a still-pressed key must re-debounce, then emit a fresh key_press.

Decomposition:
- Shared package key_pkg:
  - key FSM state enum (IDLE/HELD/LONG).
  - Key index constants: KEY_START=0, KEY_PAUSE=1.
  - ms conversion constant: 1000.
- Sub-module ms_tick_gen: parameter CLK_HZ, ports clk/reset_start/ms_tick.
- Per-key logic sits in a generate loop inside key_conditioner; no separate module.

Test Plan:
All scenarios use CLK_HZ=10_000 (TICK_DIV=10), DEBOUNCE_MS=3, LONG_MS=10, REPEAT_MS=4, ACTIVE_LOW=1.
- Glitch rejection: key_in[0] low for 15 clk, then high -> key_level[0] stays 0; no key_press or key_release.
- Clean press: key_in[0] low for 28 ms, then high -> one key_press about 3 ms after the edge; one key_long 10 ticks after key_press; exactly 4 key_repeat (ticks 14/18/22/26); one key_release about 3 ms after the raw release.
- Bounce: key_in[1] toggles every 5 clk for 2 ms, then stays low -> exactly one key_press[1], 3 ms after the bouncing stops; key_level[1] has no intermediate toggles.
- Simultaneous keys: both keys low in the same cycle for 5 ms -> key_press[0] and key_press[1] in the same cycle; no key_long; key_release on both in the same cycle.
- Reset mid-hold: assert reset_start at 12 ms into a press -> all outputs 0 immediately. Deassert with the key still held -> key_press again 3 ms later; key_long 10 ticks after that.
- Tick: free run of 100 clk -> ms_tick pulses exactly 10 times, spaced 10 clk apart, each 1 clk wide.
